wb_arbiter_3m: RTL and testbench



---
 rtl/wb_arbiter_3m.sv | 266 ++++++++++++++++++++++++++
 tb/tb_wb_arbiter_3m.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_3m.sv
// Three-master to one-slave Wishbone arbiter (icache_0, icache_1, dcache).
// Round-robin grant held for the whole cyc of the winning master; slave
// responses are steered only to the granted master.
// Optional stall timeout with abort: define WB_ARB_TIMEOUT_EN.
module wb_arbiter_3m #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // master 0 (icache_0)
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_o_dat,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic              m0_4_burst,
  input  logic              m0_8_burst,
  output logic [DATA_W-1:0] m0_i_dat,
  output logic              m0_ack,
  output logic              m0_err,
  // master 1 (icache_1)
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_o_dat,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic              m1_4_burst,
  input  logic              m1_8_burst,
  output logic [DATA_W-1:0] m1_i_dat,
  output logic              m1_ack,
  output logic              m1_err,
  // master 2 (dcache)
  input  logic              m2_cyc,
  input  logic              m2_stb,
  input  logic              m2_we,
  input  logic [ADDR_W-1:0] m2_adr,
  input  logic [DATA_W-1:0] m2_o_dat,
  input  logic [SEL_W-1:0]  m2_sel,
  input  logic              m2_4_burst,
  input  logic              m2_8_burst,
  output logic [DATA_W-1:0] m2_i_dat,
  output logic              m2_ack,
  output logic              m2_err,
  // slave side (inner bus)
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_o_dat,
  output logic [SEL_W-1:0]  s_sel,
  output logic              s_4_burst,
  output logic              s_8_burst,
  input  logic [DATA_W-1:0] s_i_dat,
  input  logic              s_ack,
  input  logic              s_err,
  // debug
  output logic [1:0]        o_grant
);

  typedef enum logic [2:0] {
    IDLE,
    G0,
    G1,
    G2
`ifdef WB_ARB_TIMEOUT_EN
    , ABORT
`endif
  } state_t;

  state_t     state_p0, state_nxt;
  logic [1:0] last_p0, last_nxt;
  logic       to_hit;

  // Round-robin pick: search last+1, last+2, last+3 (mod 3); 3 means no request.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] p;
    p = 2'd3;
    case (last)
      2'd0:    p = req[1] ? 2'd1 : req[2] ? 2'd2 : req[0] ? 2'd0 : 2'd3;
      2'd1:    p = req[2] ? 2'd2 : req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd3;
      default: p = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
    endcase
    return p;
  endfunction

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = TIMEOUT_CYC[7:0];

  logic [7:0] to_cnt_p0;
  logic [1:0] abort_p0, abort_nxt;
  logic       abort_cyc;
  logic       in_grant;

  assign in_grant  = (state_p0 == G0) || (state_p0 == G1) || (state_p0 == G2);
  assign to_hit    = in_grant && (to_cnt_p0 == TO_LIM);
  assign abort_cyc = (abort_p0 == 2'd0) ? m0_cyc :
                     (abort_p0 == 2'd1) ? m1_cyc : m2_cyc;

  // Stall counter: counts unanswered strobes while granted, clears on any response or state change.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt_p0 <= 8'd0;
      abort_p0  <= 2'd0;
    end else begin
      abort_p0 <= abort_nxt;
      if (!in_grant || (state_nxt != state_p0) || s_ack || s_err)
        to_cnt_p0 <= 8'd0;
      else if (s_stb)
        to_cnt_p0 <= to_cnt_p0 + 8'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Grant state and round-robin pointer registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_p0 <= IDLE;
      last_p0  <= 2'd2;
    end else begin
      state_p0 <= state_nxt;
      last_p0  <= last_nxt;
    end
  end

  // Next-state: arbitrate only from IDLE; a grant ends when its master drops cyc.
  always_comb begin
    state_nxt = state_p0;
    last_nxt  = last_p0;
`ifdef WB_ARB_TIMEOUT_EN
    abort_nxt = abort_p0;
`endif
    case (state_p0)
      IDLE: begin
        case (rr_pick(last_p0, {m2_cyc, m1_cyc, m0_cyc}))
          2'd0:    state_nxt = G0;
          2'd1:    state_nxt = G1;
          2'd2:    state_nxt = G2;
          default: state_nxt = IDLE;
        endcase
      end
      G0: begin
        if (!m0_cyc) begin
          state_nxt = IDLE;
          last_nxt  = 2'd0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_nxt = ABORT;
          abort_nxt = 2'd0;
        end
`endif
      end
      G1: begin
        if (!m1_cyc) begin
          state_nxt = IDLE;
          last_nxt  = 2'd1;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_nxt = ABORT;
          abort_nxt = 2'd1;
        end
`endif
      end
      G2: begin
        if (!m2_cyc) begin
          state_nxt = IDLE;
          last_nxt  = 2'd2;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (to_hit) begin
          state_nxt = ABORT;
          abort_nxt = 2'd2;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (!abort_cyc) begin
          state_nxt = IDLE;
          last_nxt  = abort_p0;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Bus mux: granted master drives the slave, slave responses go back to it alone.
  always_comb begin
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_o_dat   = '0;
    s_sel     = '0;
    s_4_burst = 1'b0;
    s_8_burst = 1'b0;
    m0_i_dat  = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m1_i_dat  = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m2_i_dat  = '0;
    m2_ack    = 1'b0;
    m2_err    = 1'b0;
    o_grant   = 2'd3;
    case (state_p0)
      G0: begin
        s_cyc     = m0_cyc;
        s_stb     = m0_stb;
        s_we      = m0_we;
        s_adr     = m0_adr;
        s_o_dat   = m0_o_dat;
        s_sel     = m0_sel;
        s_4_burst = m0_4_burst;
        s_8_burst = m0_8_burst;
        m0_i_dat  = s_i_dat;
        m0_ack    = s_ack;
        m0_err    = s_err | to_hit;
        o_grant   = 2'd0;
      end
      G1: begin
        s_cyc     = m1_cyc;
        s_stb     = m1_stb;
        s_we      = m1_we;
        s_adr     = m1_adr;
        s_o_dat   = m1_o_dat;
        s_sel     = m1_sel;
        s_4_burst = m1_4_burst;
        s_8_burst = m1_8_burst;
        m1_i_dat  = s_i_dat;
        m1_ack    = s_ack;
        m1_err    = s_err | to_hit;
        o_grant   = 2'd1;
      end
      G2: begin
        s_cyc     = m2_cyc;
        s_stb     = m2_stb;
        s_we      = m2_we;
        s_adr     = m2_adr;
        s_o_dat   = m2_o_dat;
        s_sel     = m2_sel;
        s_4_burst = m2_4_burst;
        s_8_burst = m2_8_burst;
        m2_i_dat  = s_i_dat;
        m2_ack    = s_ack;
        m2_err    = s_err | to_hit;
        o_grant   = 2'd2;
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: o_grant = abort_p0;
`endif
      default: o_grant = 2'd3;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_3m.sv
// Self-checking bench for wb_arbiter_3m: directed scenarios with a scoreboard
// of expected grant order and expected read data per master.
module tb_wb_arbiter_3m;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          mcyc[3], mstb[3], mwe[3], mb4[3], mb8[3];
  logic [AW-1:0] madr[3];
  logic [DW-1:0] mdat[3];
  logic [SW-1:0] msel[3];
  logic [DW-1:0] midat[3];
  logic          mack[3], merr[3];
  logic          s_cyc, s_stb, s_we, s_4_burst, s_8_burst;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_o_dat, s_i_dat;
  logic [SW-1:0] s_sel;
  logic          s_ack, s_err;
  logic [1:0]    o_grant;

  int n_chk = 0;
  int n_err = 0;

  logic [1:0]    gq[$];
  logic [DW-1:0] q0[$], q1[$], q2[$];
  logic [1:0]    prev_grant = 2'd3;

  always #5 clk = ~clk;

  wb_arbiter_3m #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_adr(madr[0]),
    .m0_o_dat(mdat[0]), .m0_sel(msel[0]), .m0_4_burst(mb4[0]), .m0_8_burst(mb8[0]),
    .m0_i_dat(midat[0]), .m0_ack(mack[0]), .m0_err(merr[0]),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_adr(madr[1]),
    .m1_o_dat(mdat[1]), .m1_sel(msel[1]), .m1_4_burst(mb4[1]), .m1_8_burst(mb8[1]),
    .m1_i_dat(midat[1]), .m1_ack(mack[1]), .m1_err(merr[1]),
    .m2_cyc(mcyc[2]), .m2_stb(mstb[2]), .m2_we(mwe[2]), .m2_adr(madr[2]),
    .m2_o_dat(mdat[2]), .m2_sel(msel[2]), .m2_4_burst(mb4[2]), .m2_8_burst(mb8[2]),
    .m2_i_dat(midat[2]), .m2_ack(mack[2]), .m2_err(merr[2]),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_o_dat(s_o_dat),
    .s_sel(s_sel), .s_4_burst(s_4_burst), .s_8_burst(s_8_burst),
    .s_i_dat(s_i_dat), .s_ack(s_ack), .s_err(s_err),
    .o_grant(o_grant)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (sample point).
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0; mb4[i] = 1'b0; mb8[i] = 1'b0;
      madr[i] = '0; mdat[i] = '0; msel[i] = '0;
    end
    s_i_dat = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
  endtask

  task automatic req(input int n, input logic we);
    mcyc[n] = 1'b1;
    mstb[n] = 1'b1;
    mwe[n]  = we;
  endtask

  task automatic push_rd(input int n, input logic [DW-1:0] d);
    s_i_dat = d;
    case (n)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic do_reset();
    step();
    i_rst = 1'b1;
    clear_inputs();
    step();
    settle();
    chk("rst_grant", {30'd0, o_grant}, 32'd3);
    chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    step();
    i_rst = 1'b0;
  endtask

  task automatic release_all();
    step();
    clear_inputs();
    step();
    step();
  endtask

  // Scoreboard: grant acquisitions against expected order, acks against expected read data.
  always @(negedge clk) begin
    if (o_grant != 2'd3 && prev_grant == 2'd3) begin
      if (gq.size() == 0) chk("grant_unexp", {30'd0, o_grant}, 32'd3);
      else chk("grant_order", {30'd0, o_grant}, {30'd0, gq.pop_front()});
    end
    prev_grant <= o_grant;
    if (mack[0] === 1'b1) begin
      if (q0.size() == 0) chk("m0_ack_unexp", 32'd1, 32'd0);
      else chk("m0_rdata", {16'd0, midat[0]}, {16'd0, q0.pop_front()});
    end
    if (mack[1] === 1'b1) begin
      if (q1.size() == 0) chk("m1_ack_unexp", 32'd1, 32'd0);
      else chk("m1_rdata", {16'd0, midat[1]}, {16'd0, q1.pop_front()});
    end
    if (mack[2] === 1'b1) begin
      if (q2.size() == 0) chk("m2_ack_unexp", 32'd1, 32'd0);
      else chk("m2_rdata", {16'd0, midat[2]}, {16'd0, q2.pop_front()});
    end
  end

  initial begin
    int g;
    int w;
    i_rst = 1'b1;
    clear_inputs();

    // single m2 write
    do_reset();
    gq.push_back(2'd2);
    step();
    req(2, 1'b1); madr[2] = 24'h000120; mdat[2] = 16'hBEEF; msel[2] = 2'b11;
    settle();
    chk("t1_latency_cyc", {31'd0, s_cyc}, 32'd0);
    step();
    settle();
    chk("t1_s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("t1_s_adr", {8'd0, s_adr}, 32'h000120);
    chk("t1_s_dat", {16'd0, s_o_dat}, 32'h0000BEEF);
    chk("t1_s_we", {31'd0, s_we}, 32'd1);
    chk("t1_s_sel", {30'd0, s_sel}, 32'd3);
    step();
    s_ack = 1'b1; push_rd(2, 16'h0000);
    settle();
    chk("t1_m2_ack", {31'd0, mack[2]}, 32'd1);
    chk("t1_m0m1_ack", {30'd0, mack[1], mack[0]}, 32'd0);
    release_all();

    // round robin with all three requesting
    do_reset();
    gq.push_back(2'd0); gq.push_back(2'd1); gq.push_back(2'd2); gq.push_back(2'd0);
    step();
    req(0, 1'b0); req(1, 1'b0); req(2, 1'b0);
    settle();
    for (int k = 0; k < 4; k++) begin
      w = 0;
      do begin
        step(); settle(); w++;
      end while (o_grant == 2'd3 && w < 10);
      if (o_grant == 2'd3) begin
        chk("rr_wait", 32'd3, 32'd0);
        break;
      end
      g = int'(o_grant);
      step();
      s_ack = 1'b1; push_rd(g, 16'(16'h2000 + k));
      settle();
      step();
      s_ack = 1'b0; mcyc[g] = 1'b0; mstb[g] = 1'b0;
      settle();
      step();
      mcyc[g] = (k < 3); mstb[g] = (k < 3);
      if (k == 3) clear_inputs();
      settle();
      chk("rr_idle_gap", {30'd0, o_grant}, 32'd3);
    end
    release_all();

    // m0 8-beat burst while m2 waits
    do_reset();
    gq.push_back(2'd0);
    step();
    req(0, 1'b0); mb8[0] = 1'b1;
    settle();
    step();
    req(2, 1'b0);
    settle();
    chk("t3_grant0", {30'd0, o_grant}, 32'd0);
    chk("t3_s_8_burst", {31'd0, s_8_burst}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      s_ack = 1'b1; push_rd(0, 16'(16'h1000 + i));
      settle();
      chk("t3_burst_hold", {30'd0, o_grant}, 32'd0);
      chk("t3_m2_idat", {16'd0, midat[2]}, 32'd0);
    end
    step();
    s_ack = 1'b0; mcyc[0] = 1'b0; mstb[0] = 1'b0; mb8[0] = 1'b0;
    gq.push_back(2'd2);
    settle();
    chk("t3_still_g0", {30'd0, o_grant}, 32'd0);
    step(); settle();
    chk("t3_idle", {30'd0, o_grant}, 32'd3);
    step(); settle();
    chk("t3_grant2", {30'd0, o_grant}, 32'd2);
    release_all();

    // ack while IDLE, then err during a G1 read
    do_reset();
    step();
    s_ack = 1'b1; s_i_dat = 16'hDEAD;
    settle();
    chk("t4_idle_ack", {29'd0, mack[2], mack[1], mack[0]}, 32'd0);
    chk("t4_idle_idat", {16'd0, midat[0] | midat[1] | midat[2]}, 32'd0);
    step();
    s_ack = 1'b0; s_i_dat = '0;
    gq.push_back(2'd1);
    req(1, 1'b0);
    settle();
    step(); settle();
    chk("t4_grant1", {30'd0, o_grant}, 32'd1);
    step();
    s_err = 1'b1;
    settle();
    chk("t4_m1_err", {31'd0, merr[1]}, 32'd1);
    chk("t4_m0m2_err", {30'd0, merr[2], merr[0]}, 32'd0);
    chk("t4_m1_ack", {31'd0, mack[1]}, 32'd0);
    step();
    s_err = 1'b0;
    settle();
    chk("t4_grant_kept", {30'd0, o_grant}, 32'd1);
    step();
    mcyc[1] = 1'b0; mstb[1] = 1'b0;
    settle();
    chk("t4_grant_kept2", {30'd0, o_grant}, 32'd1);
    step(); settle();
    chk("t4_release", {30'd0, o_grant}, 32'd3);
    release_all();

    // reset in the third cycle of an m1 burst
    do_reset();
    gq.push_back(2'd1);
    step();
    req(1, 1'b0); mb4[1] = 1'b1;
    settle();
    step();
    s_ack = 1'b1; push_rd(1, 16'h3000);
    settle();
    chk("t5_s_4_burst", {31'd0, s_4_burst}, 32'd1);
    step();
    push_rd(1, 16'h3001);
    settle();
    step();
    s_ack = 1'b0; i_rst = 1'b1;
    settle();
    step();
    i_rst = 1'b0; s_ack = 1'b1; s_i_dat = 16'h3002;
    req(0, 1'b0);
    gq.push_back(2'd0);
    settle();
    chk("t5_rst_grant", {30'd0, o_grant}, 32'd3);
    chk("t5_rst_s_cyc", {30'd0, s_cyc, s_stb}, 32'd0);
    chk("t5_rst_m1_ack", {31'd0, mack[1]}, 32'd0);
    step();
    s_ack = 1'b0;
    settle();
    chk("t5_m0_wins", {30'd0, o_grant}, 32'd0);
    release_all();

`ifdef WB_ARB_TIMEOUT_EN
    // stalled slave: timeout abort after 16 stall cycles
    do_reset();
    gq.push_back(2'd2);
    step();
    req(2, 1'b0);
    settle();
    step(); settle();
    chk("t6_s_stb", {31'd0, s_stb}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      step(); settle();
      if (i < 16) chk("t6_no_early_err", {31'd0, merr[2]}, 32'd0);
      else chk("t6_err_pulse", {31'd0, merr[2]}, 32'd1);
    end
    step(); settle();
    chk("t6_err_once", {31'd0, merr[2]}, 32'd0);
    chk("t6_abort_cyc", {30'd0, s_cyc, s_stb}, 32'd0);
    chk("t6_abort_grant", {30'd0, o_grant}, 32'd2);
    step();
    mcyc[2] = 1'b0; mstb[2] = 1'b0;
    settle();
    chk("t6_abort_hold", {30'd0, o_grant}, 32'd2);
    step(); settle();
    chk("t6_idle", {30'd0, o_grant}, 32'd3);
    gq.push_back(2'd2);
    step();
    req(2, 1'b0);
    settle();
    step(); settle();
    chk("t6_regrant_cyc", {31'd0, s_cyc}, 32'd1);
    step();
    s_ack = 1'b1; push_rd(2, 16'h4242);
    settle();
    chk("t6_regrant_ack", {31'd0, mack[2]}, 32'd1);
    release_all();
`else
    // stalled slave without timeout: bus stays blocked
    do_reset();
    gq.push_back(2'd2);
    step();
    req(2, 1'b0);
    settle();
    repeat (40) step();
    settle();
    chk("t6_no_err", {31'd0, merr[2]}, 32'd0);
    chk("t6_still_g2", {30'd0, o_grant}, 32'd2);
    chk("t6_still_cyc", {31'd0, s_cyc}, 32'd1);
    release_all();
`endif

    chk("sb_grant_left", gq.size(), 32'd0);
    chk("sb_data_left", q0.size() + q1.size() + q2.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Hard stop in case a scenario stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
